// File: rtl/simon32_64_core.sv
// simon32_64_core
// Iterative SIMON 32/64 block cipher: expands the 64-bit key into a 32-entry
// round-key file (one key per cycle), then applies 32 rounds (one per cycle)
// to encrypt or decrypt one 32-bit block.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   start         begin an operation (honoured in IDLE and DONE only)
//   cryp_decryp   1 = encrypt, 0 = decrypt; sampled with start
//   k_in[7:0]     key bytes; kw[j] = {k_in[2j+1], k_in[2j]}
//   text_in[3:0]  input block; x = {text_in[3], text_in[2]}, y = {text_in[1], text_in[0]}
//   crypt_out     registered result, same byte packing as text_in
//   result_ready  high while a result is held (DONE)
//   busy          high while expanding keys or running rounds
module simon32_64_core (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            cryp_decryp,
  input  logic [7:0][7:0] k_in,
  input  logic [3:0][7:0] text_in,
  output logic [3:0][7:0] crypt_out,
  output logic            result_ready,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

  // z0 sequence written left to right; sequence index k lives at bit 61-k.
  localparam logic [61:0] Z0 =
    62'b1111101000_1001010110_0001110011_0111110100_0100101011_0000111001_10;

  state_t      state, state_nxt;
  logic [15:0] rk [32];
  logic [15:0] x, y;
  logic [4:0]  i;
  logic        mode;

  // ---------------- key expansion ----------------
  logic [15:0] rk_m1, rk_m3, rk_m4, tmp0, tmp1, rk_new;
  logic [4:0]  zk;
  logic [5:0]  zidx;
  logic        zbit;

  always_comb begin
    rk_m1  = rk[i - 5'd1];
    rk_m3  = rk[i - 5'd3];
    rk_m4  = rk[i - 5'd4];
    tmp0   = {rk_m1[2:0], rk_m1[15:3]} ^ rk_m3;   // ror3(rk[i-1]) ^ rk[i-3]
    tmp1   = tmp0 ^ {tmp0[0], tmp0[15:1]};        // tmp ^ ror1(tmp)
    zk     = i - 5'd4;
    zidx   = 6'd61 - {1'b0, zk};
    zbit   = Z0[zidx];
    rk_new = ~rk_m4 ^ tmp1 ^ {15'd0, zbit} ^ 16'h0003;
  end

  // ---------------- round function ----------------
  function automatic logic [15:0] f_rnd(input logic [15:0] v);
    f_rnd = ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  logic [15:0] x_nxt, y_nxt, rk_enc, rk_dec;

  always_comb begin
    rk_enc = rk[i];
    rk_dec = rk[5'd31 - i];
    if (mode) begin
      x_nxt = y ^ f_rnd(x) ^ rk_enc;
      y_nxt = x;
    end else begin
      x_nxt = y;
      y_nxt = x ^ f_rnd(y) ^ rk_dec;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)     state_nxt = EXPAND;
      EXPAND:     if (i == 5'd31) state_nxt = ROUND;
      ROUND:      if (i == 5'd31) state_nxt = DONE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign result_ready = (state == DONE);
  assign busy         = (state == EXPAND) || (state == ROUND);

  // ---------------- datapath ----------------
  // x, y, mode and rk carry no reset: they are always reloaded by start
  // before being used.
  always_ff @(posedge clk) begin
    if (reset) begin
      i         <= '0;
      crypt_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x     <= {text_in[3], text_in[2]};
            y     <= {text_in[1], text_in[0]};
            rk[0] <= {k_in[1], k_in[0]};
            rk[1] <= {k_in[3], k_in[2]};
            rk[2] <= {k_in[5], k_in[4]};
            rk[3] <= {k_in[7], k_in[6]};
            mode  <= cryp_decryp;
            i     <= 5'd4;
          end
        end
        EXPAND: begin
          rk[i] <= rk_new;
          i     <= i + 5'd1;   // 31 wraps to 0, ready for the first round
        end
        ROUND: begin
          x <= x_nxt;
          y <= y_nxt;
          i <= i + 5'd1;
          if (i == 5'd31) crypt_out <= {x_nxt, y_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon32_64_core.sv
// tb_simon32_64_core
// Directed and random checks of simon32_64_core against known answers and a
// reference model, with expected results queued at stimulus time.
module tb_simon32_64_core;

  logic            clk = 1'b0;
  logic            reset, start, cryp_decryp;
  logic [7:0][7:0] k_in;
  logic [3:0][7:0] text_in;
  logic [3:0][7:0] crypt_out;
  logic            result_ready, busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;

  always #5 clk = ~clk;

  simon32_64_core dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cryp_decryp (cryp_decryp),
    .k_in        (k_in),
    .text_in     (text_in),
    .crypt_out   (crypt_out),
    .result_ready(result_ready),
    .busy        (busy)
  );

  function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
    rotl = (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [31:0] model(input logic [63:0] key, input logic [31:0] blk,
                                        input logic enc);
    logic [15:0] k [32];
    logic [15:0] a, b, t;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int j = 0; j < 4; j++) k[j] = key[16*j +: 16];
    for (int j = 4; j < 32; j++) begin
      t = rotl(k[j-1], 13) ^ k[j-3];
      t = t ^ rotl(t, 15);
      k[j] = ~k[j-4] ^ t ^ 16'(z[61-(j-4)]) ^ 16'd3;
    end
    a = blk[31:16];
    b = blk[15:0];
    if (enc) begin
      for (int r = 0; r < 32; r++) begin
        t = a;
        a = b ^ ((rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2)) ^ k[r];
        b = t;
      end
    end else begin
      for (int r = 31; r >= 0; r--) begin
        t = b;
        b = a ^ ((rotl(b, 1) & rotl(b, 8)) ^ rotl(b, 2)) ^ k[r];
        a = t;
      end
    end
    model = {a, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Call at a negedge; returns at the negedge after the start edge.
  task automatic start_op(input logic [63:0] key, input logic [31:0] blk, input logic enc,
                          input logic [31:0] expv);
    k_in        = key;
    text_in     = blk;
    cryp_decryp = enc;
    start       = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for result_ready; checks latency, busy, hold and result.
  task automatic wait_done(input string tag, input bit disturb, output logic [31:0] res);
    int          n;
    int          hold_err;
    logic [31:0] prev, expv;
    n        = 0;
    hold_err = 0;
    prev     = crypt_out;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_ready_start"}, 32'(result_ready), 32'd0);
    while (!result_ready && n < 100) begin
      @(negedge clk);
      n++;
      if (disturb && (n == 10 || n == 40)) begin
        start       = 1'b1;
        text_in     = $urandom;
        k_in        = {$urandom, $urandom};
        cryp_decryp = ~cryp_decryp;
      end else begin
        start = 1'b0;
      end
      if (!result_ready && crypt_out !== prev) hold_err++;
    end
    start = 1'b0;
    res   = crypt_out;
    chk({tag, "_latency"}, 32'(n), 32'd60);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(hold_err), 32'd0);
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      chk({tag, "_result"}, crypt_out, expv);
    end else begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] r, ct, rt, pt, cm;
    logic [63:0] key;
    reset       = 1'b1;
    start       = 1'b0;
    cryp_decryp = 1'b0;
    k_in        = '0;
    text_in     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(result_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", crypt_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Encrypt known answer
    start_op(KAT_KEY, KAT_PT, 1'b1, KAT_CT);
    wait_done("kat_enc", 1'b0, r);

    // Decrypt known answer, started on the first DONE cycle (back-to-back)
    start_op(KAT_KEY, KAT_CT, 1'b0, KAT_PT);
    wait_done("kat_dec_b2b", 1'b0, r);

    // start and text_in disturbed during EXPAND and ROUND
    @(negedge clk);
    start_op(KAT_KEY, KAT_PT, 1'b1, KAT_CT);
    wait_done("disturb", 1'b1, r);

    // Reset mid-operation
    @(negedge clk);
    start_op(KAT_KEY, KAT_PT, 1'b1, KAT_CT);
    repeat (34) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(result_ready), 32'd0);
    chk("midrst_out", crypt_out, 32'd0);
    reset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    start_op(KAT_KEY, KAT_PT, 1'b1, KAT_CT);
    wait_done("post_rst", 1'b0, r);

    // Random round trips
    for (int it = 0; it < 200; it++) begin
      key = {$urandom, $urandom};
      pt  = $urandom;
      cm  = model(key, pt, 1'b1);
      @(negedge clk);
      start_op(key, pt, 1'b1, cm);
      wait_done("rnd_enc", 1'b0, ct);
      @(negedge clk);
      start_op(key, ct, 1'b0, model(key, ct, 1'b0));
      wait_done("rnd_dec", 1'b0, rt);
      chk("rnd_trip", rt, pt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simon32_64_core.md
# simon32_64_core

Iterative SIMON 32/64 block cipher engine, encrypting or decrypting one 32-bit block under a 64-bit key. Sits directly downstream of the UART command FSM: it consumes the FSM's `k_in`, `text_in` and `cryp_decryp` outputs, and returns `crypt_out` and `result_ready` for the FSM to transmit. The key schedule is expanded into an internal round-key file, then 32 rounds are applied at one round per cycle.

## Interface
Parameters: none. The algorithm is fixed at n=16, m=4, T=32, z0.

- `clk` in 1 — clock
- `reset` in 1 — reset, synchronous, active-high; clock clk
- `start` in 1 — begin an operation; sampled in IDLE and DONE only
- `cryp_decryp` in 1 — 1 = encrypt, 0 = decrypt; sampled with `start`
- `k_in[7:0]` in 8×8 — key bytes; word kw[j] = {k_in[2j+1], k_in[2j]}; kw[0] is the first round key
- `text_in[3:0]` in 4×8 — block; x = {text_in[3], text_in[2]}, y = {text_in[1], text_in[0]}
- `crypt_out[3:0]` out 4×8 — result, same byte packing as `text_in`; registered
- `result_ready` out 1 — level signal; high while in DONE
- `busy` out 1 — high in EXPAND and ROUND

## Operation
- Storage:
  - rk[0..31], 16-bit round-key file.
  - x, y, 16-bit state registers.
  - 5-bit index i.
  - mode flag.
- IDLE:
  - On `start`:
    - Latch x, y from `text_in`.
    - Load rk[0..3] = kw[0..3].
    - Latch mode = `cryp_decryp`.
    - Set i=4 and go to EXPAND.
  - Otherwise stay in IDLE.
- EXPAND: one round key per cycle.
  - Compute tmp = ror3(rk[i-1]) ^ rk[i-3].
  - Then tmp = tmp ^ ror1(tmp).
  - Then rk[i] = ~rk[i-4] ^ tmp ^ z0[i-4] ^ 16'h0003.
  - z0[i-4] is the z0 bit, XORed into bit 0 only.
  - z0 = 11111010001001010110000111001101111101000100101011000011100110. Bit index 0 is the leftmost bit. Only indices 0..27 are used.
  - Increment i. When i==31 is written, set i=0 and go to ROUND.
- ROUND: one round per cycle, with f(v) = (rol1(v) & rol8(v)) ^ rol2(v).
  - Encrypt: (x, y) ← (y ^ f(x) ^ rk[i], x).
  - Decrypt: (x, y) ← (y, x ^ f(y) ^ rk[31-i]).
  - Increment i. On the round with i==31:
    - Load `crypt_out` from the final x, y.
    - Go to DONE.
- DONE:
  - `result_ready` = 1 and `crypt_out` is held.
  - On `start`, perform the same actions as IDLE-on-start. `result_ready` falls on the next cycle.
- `start` in EXPAND or ROUND is ignored. The operation in flight is neither aborted nor restarted.
- Inputs other than `start` and `cryp_decryp` are don't-care outside the `start` cycle. Changing `k_in` or `text_in` mid-operation has no effect.
- All rotations are modulo 16; all arithmetic is 16-bit with no carries.

## Timing
- Reset values:
  - State = IDLE.
  - `crypt_out` = all 0x00.
  - `result_ready` = 0.
  - `busy` = 0.
  - i = 0.
  - x, y, rk contents are don't-care.
- Reset mid-operation: on the next edge, return to IDLE with the outputs above. Any partial result is discarded.
- Latency, with `start` sampled at edge E0:
  - EXPAND occupies edges E1..E28.
  - ROUND occupies edges E29..E60.
  - `result_ready` and the new `crypt_out` are visible after E60, i.e. 60 cycles from the start edge.
- `busy` rises after E0 and falls after E60, in the same cycle that `result_ready` rises.
- Throughput: one block per 61 cycles when `start` is asserted on the first DONE cycle.
- `start` held high continuously: re-triggers on every entry to DONE. DONE lasts exactly one cycle in this case.

## Test plan
- Encrypt known answer. Stimulus:
  - k_in[0..7] = 00,01,08,09,10,11,18,19.
  - text_in[3..0] = 65,65,68,77.
  - encrypt.
  - Required response: `crypt_out[3..0]` = C6,9B,E9,BB, with `result_ready` high exactly 60 cycles after the start edge.
- Decrypt known answer. Stimulus:
  - Same key.
  - text_in[3..0] = C6,9B,E9,BB.
  - decrypt.
  - Required response: `crypt_out` = 65,65,68,77 after 60 cycles.
- Random round-trip, 200 iterations. Stimulus: random key and block, encrypt, then decrypt the result. Required response: the original block is recovered, and each result matches a software model.
- `start` pulsed during EXPAND (cycle 10) and during ROUND (cycle 40), with `text_in` changed at the same time. Required response: the result and latency are identical to the undisturbed run.
- `reset` asserted at cycle 35 of an operation. Required response:
  - `busy` = 0, `result_ready` = 0, `crypt_out` = 0 after the next edge.
  - A fresh encrypt of the known-answer vector then still yields C6,9B,E9,BB.
- Back-to-back operation. Stimulus: `start` asserted in the first DONE cycle with a new block. Required response:
  - `result_ready` drops for exactly 60 cycles.
  - `crypt_out` holds the old value until the new result lands.
